// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM encoding, reset PC default,
// opcode constants and small decode helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic        unused_op;

  // The opcode field is decoded upstream; only the target/immediate matter here.
  assign unused_op  = ^instr[31:26];
  assign pc4        = pc + 32'd4;
  assign branch_off = sext_imm(instr[15:0]) << 2;

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing: owns the PC, fetches over req/ack and
// hands each instruction to decode over valid/ready.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] instret
);

  // Handshakes: a fetch completes on an edge with imem_req && imem_ack; an
  // instruction retires on an edge with instr_valid && instr_ready, which is
  // also the only edge where jump/branch/zero are sampled. Req and addr hold
  // steady until the ack, and instr holds steady until retirement.

  fetch_state_t state, state_n;
  logic [31:0]  pc_n, instr_n, instret_n, next_pc;
  logic         imem_req_n, instr_valid_n;

  next_pc_calc u_next_pc (
    .pc      (pc),
    .instr   (instr),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      instret     <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= instr_valid_n;
      imem_req    <= imem_req_n;
      instret     <= instret_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_valid_n = instr_valid;
    imem_req_n    = imem_req;
    instret_n     = instret;
    case (state)
      IDLE: begin
        imem_req_n = 1'b1;
        state_n    = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_n       = imem_rdata;
          instr_valid_n = 1'b1;
          imem_req_n    = 1'b0;
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          pc_n          = next_pc;
          instret_n     = instret + 32'd1;
          instr_valid_n = 1'b0;
          imem_req_n    = 1'b1;
          state_n       = FETCH;
        end
      end
      default: begin
        state_n       = IDLE;
        instr_valid_n = 1'b0;
        imem_req_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0, branch = 1'b0, zero = 1'b0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, instret;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_instr, d2_pc, d2_instret;

  int n_chk = 0;
  int n_err = 0;

  // Model: phase 0 = waiting to start, 1 = fetch outstanding, 2 = holding instr.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_instret = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump(jump),
    .branch(branch), .zero(zero), .pc(pc), .instret(instret)
  );

  // Second instance in lockstep, used only to reach a PC in the 0x3xxxxxxx region.
  fetch_unit #(.RESET_PC(32'h3000_0000)) dut2 (
    .clk(clk), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(d2_instr),
    .instr_valid(d2_valid), .instr_ready(instr_ready), .jump(jump),
    .branch(branch), .zero(zero), .pc(d2_pc), .instret(d2_instret)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic j, input logic b, input logic z);
    logic [31:0] p4;
    logic [15:0] imm;
    int          off;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      imm = ins[15:0];
      off = $signed(imm);
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase   = 0;
      m_pc      = 32'h0;
      m_instr   = 32'h0;
      m_instret = 32'h0;
    end else begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_phase = 2;
        end
      end else if (instr_ready) begin
        m_pc      = ref_next(m_pc, m_instr, jump, branch, zero);
        m_instret = m_instret + 32'd1;
        m_phase   = 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("req", {31'd0, imem_req}, {31'd0, m_phase == 1});
      chk("valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
      chk("addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("instret", instret, m_instret);
      if (m_phase == 2) chk("instr", instr, m_instr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic a, input logic [31:0] rd, input logic r,
                      input logic j, input logic b, input logic z);
    imem_ack = a; imem_rdata = rd; instr_ready = r;
    jump = j; branch = b; zero = z;
    @(posedge clk); #1;
  endtask

  // Fetch with some wait cycles, then retire with the given controls.
  task automatic run_instr(input logic [31:0] rd, input int waits,
                           input logic j, input logic b, input logic z);
    logic [31:0] a0;
    if (m_phase == 0) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    a0 = imem_addr;
    for (int w = 0; w < waits; w++) begin
      step(1'b0, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, a0);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    step(1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("ack_instr", instr, rd);
    chk("ack_req", {31'd0, imem_req}, 32'd0);
    step(1'b1, $urandom, 1'b1, j, b, z);
    chk("ret_valid", {31'd0, instr_valid}, 32'd0);
    chk("ret_req", {31'd0, imem_req}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] beq_m3, j_tgt, j_zero, beq_m2;
    beq_m3 = {OP_BEQ, 10'd0, 16'hFFFD};
    j_tgt  = {OP_J, 26'h010_0004};
    j_zero = {OP_J, 26'h0};
    beq_m2 = {OP_BEQ, 10'd0, 16'hFFFE};

    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    reset = 1'b0;

    // Sequential fetch 0,4,8 with three wait cycles at 4.
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_addr0", imem_addr, 32'h0);
    run_instr(32'h2008_0005, 0, 1'b0, 1'b0, 1'b0);
    chk("seq_addr1", imem_addr, 32'h4);
    run_instr(32'h2008_0005, 3, 1'b0, 1'b0, 1'b0);
    chk("seq_addr2", imem_addr, 32'h8);
    run_instr(32'h2008_0005, 0, 1'b0, 1'b0, 1'b0);
    chk("seq_instret", instret, 32'd3);
    chk("model_instret", m_instret, 32'd3);

    // Reset while waiting on ack: req drops without a clock edge.
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'h0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, imem_req}, 32'd1);
    chk("idle_ack_addr", imem_addr, 32'h0);

    // Jump priority over a taken branch, on both PC regions.
    run_instr(j_tgt, 1, 1'b1, 1'b1, 1'b1);
    chk("jmp_addr", imem_addr, 32'h0040_0010);
    chk("jmp_addr_hi", d2_addr, 32'h3040_0010);
    chk("model_jmp", m_pc, 32'h0040_0010);
    run_instr(beq_m3, 0, 1'b0, 1'b1, 1'b1);
    chk("beq_taken", imem_addr, 32'h0040_0008);
    chk("model_beq", m_pc, 32'h0040_0008);
    run_instr(j_tgt, 0, 1'b1, 1'b0, 1'b0);
    run_instr(beq_m3, 2, 1'b0, 1'b1, 1'b0);
    chk("beq_not_taken", imem_addr, 32'h0040_0014);

    // Underflowing branch to 0xFFFFFFFC, then sequential wrap to 0.
    run_instr(j_zero, 0, 1'b1, 1'b0, 1'b0);
    chk("jmp_zero", imem_addr, 32'h0);
    run_instr(beq_m2, 0, 1'b0, 1'b1, 1'b1);
    chk("beq_underflow", imem_addr, 32'hFFFF_FFFC);
    run_instr($urandom, 0, 1'b0, 1'b0, 1'b0);
    chk("pc_wrap", imem_addr, 32'h0);

    // Reset while holding an instruction.
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_instr", instr, 32'h0);
    chk("async_instret", instret, 32'h0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and sequencing stage for the MIPS core: owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction to the main decoder with a valid/ready handshake.
- Consumes the decoder's jump/branch controls and the ALU zero flag to compute the next PC.
- Sits between instruction memory and decode/execute; it is the producer end of the opcode/control interface.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; first fetch address.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction read request; held until acknowledged.
- imem_addr  out  32  word address of request (= pc); stable while imem_req high.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction to decode (op = instr[31:26]).
- instr_valid  out  1  instr is valid and awaiting retirement.
- instr_ready  in  1  downstream retires instr this cycle; jump/branch/zero valid.
- jump  in  1  decoder jump control for the current instr.
- branch  in  1  decoder branch control for the current instr.
- zero  in  1  ALU zero flag for the current instr.
- pc  out  32  address of the current instr.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset is asynchronous, active-high. While reset is high: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instret=0.
- All outputs are registered. imem_addr is driven directly from pc.
- FSM states:
  - IDLE: entered on reset. Next edge: imem_req<=1, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to ISSUE. With imem_ack=0: remain; address and req unchanged.
  - ISSUE: instr_valid=1. On an edge with instr_ready=1: pc<=next_pc, instret<=instret+1, instr_valid<=0, imem_req<=1, go to FETCH. With instr_ready=0: hold everything.
- next_pc (combinational, from the current pc/instr):
  - pc4 = pc+4.
  - If jump=1: next_pc = {pc4[31:28], instr[25:0], 2'b00}.
  - Else if branch=1 and zero=1: next_pc = pc4 + (sign-extended instr[15:0] << 2).
  - Else: next_pc = pc4.
- Priority: jump wins over branch when both are high.
- Arithmetic is modulo 2^32. pc 32'hFFFFFFFC + 4 wraps to 0. A negative branch offset that underflows also wraps.
- instret wraps from 32'hFFFFFFFF to 0.
- Timing:
  - Latency from imem_ack to instr_valid is 1 cycle.
  - Retire to next imem_req is 1 cycle.
  - Minimum 2 cycles per instruction with zero-wait memory.
- Ignored inputs:
  - imem_ack outside FETCH is ignored.
  - instr_ready outside ISSUE is ignored.
  - jump/branch/zero are sampled only on the retiring edge.
- Reset mid-operation (during FETCH wait or ISSUE) aborts immediately. imem_req drops asynchronously. The pending transaction is abandoned, and an ack arriving after reset deasserts is ignored in IDLE.
- Unsupported opcodes are not checked here; the sequence is pc4 unless jump/branch are asserted.

Decomposition:
- Shared package mips_pkg:
  - state encoding (IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2);
  - default RESET_PC constant;
  - opcode constants (OP_RTYPE, OP_J, OP_BEQ, ...) for benches.
- One combinational sub-module next_pc_calc (inputs pc, instr, jump, branch, zero; output next_pc), reusable by a future multicycle core.

Test Plan:
- Reset, zero-wait memory returning 32'h20080005 at 0, instr_ready=1, no jump/branch → imem_addr sequence 0,4,8; instr_valid one cycle after each ack; instret=3 after third retire.
- Memory inserts 3 wait cycles at addr 4 → imem_req held, imem_addr=4 stable for 4 cycles, then instr captured; instr_valid low throughout the wait.
- At pc=32'h00400010, instr=32'h1000FFFD (beq), branch=1, zero=1 → next imem_addr=32'h00400008; with zero=0 → 32'h00400014.
- At pc=32'h30000000, instr=32'h08100004, jump=1 and branch=1, zero=1 → next imem_addr=32'h30400010 (jump priority).
- pc=32'hFFFFFFFC, sequential retire → imem_addr=0. instret preset to 32'hFFFFFFFF via 2^32 retires is impractical, so force the register and retire once → instret=0.
- Assert reset while in FETCH waiting on ack → imem_req low same cycle; ack pulse during IDLE ignored; first post-reset fetch at RESET_PC with instr_valid=0.
